// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types plus the ALU BIST constants and LFSR step
// Purpose: ALU operation encoding, BIST state encoding, the Galois polynomial
//          shared by the operand and signature LFSRs, and the op table the
//          BIST cycles through.
// Ports:   none (package)
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  typedef enum logic [1:0] {
    BIST_IDLE = 2'd0,
    BIST_RUN  = 2'd1,
    BIST_DONE = 2'd2
  } bist_state_t;

  localparam logic [31:0] BIST_POLY = 32'h8020_0003;
  localparam int          NUM_OPS   = 10;
  localparam int          OP_IDX_W  = 4;

  localparam aluop_t OP_TABLE [NUM_OPS] = '{
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  };

  // One Galois shift: feedback taps are applied when the MSB falls out.
  function automatic logic [31:0] bist_step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? BIST_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - ALU operand/result interface
// Purpose: bundles the ALU operands, operation and result/flags.
// Modports: tb  - drives port_a, port_b, alu_op; reads port_o and flags
//           alu - the combinational ALU side
interface alu_if;
  import cpu_types_pkg::*;

  logic [31:0] port_a;
  logic [31:0] port_b;
  aluop_t      alu_op;
  logic [31:0] port_o;
  logic        v_flag;
  logic        n_flag;
  logic        z_flag;

  modport tb  (output port_a, port_b, alu_op, input port_o, v_flag, n_flag, z_flag);
  modport alu (input port_a, port_b, alu_op, output port_o, v_flag, n_flag, z_flag);
endinterface

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - 32-bit Galois LFSR / MISR cell
// Purpose: reset to INIT, reload from seed, or step once with xor_in folded in.
//          With xor_in tied to zero it is a plain pattern generator.
// Ports:   CLK    in  clock, rising edge
//          nRST   in  asynchronous active-low reset
//          load   in  reload q from seed (wins over en)
//          seed   in  [31:0] reload value
//          en     in  step once this cycle
//          xor_in in  [31:0] value folded into the stepped state
//          q      out [31:0] register contents
module lfsr32
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] INIT = 32'h0000_0001
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        en,
  input  logic [31:0] xor_in,
  output logic [31:0] q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= INIT;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= bist_step(q) ^ xor_in;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU built-in self-test sequencer with MISR signature
// Purpose: drives pseudo-random operands and every ALU op, one vector per
//          cycle, folds result and flags into a MISR and compares it with a
//          golden signature at the end of the run.
// Ports:   CLK         in  clock, rising edge
//          nRST        in  asynchronous active-low reset
//          start       in  begin a run (accepted in IDLE/DONE only)
//          abort       in  abandon run, back to IDLE (beats start)
//          num_vectors in  [CNT_W-1:0] vectors to apply, latched on start
//          golden      in  [31:0] expected signature, latched on start
//          busy        out high while vectors are being applied
//          done        out high in DONE until the next accepted start
//          pass        out final signature matched golden
//          signature   out [31:0] current MISR contents
//          aluif       if  alu_if.tb towards the ALU
module alu_bist
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] SEED_A    = 32'h1234_5678,
  parameter logic [31:0] SEED_B    = 32'h9ABC_DEF0,
  parameter logic [31:0] MISR_SEED = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [31:0]      golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature,
  alu_if.tb                aluif
);

  bist_state_t         state_q, state_d;
  logic [CNT_W-1:0]    count_q, nv_q;
  logic [OP_IDX_W-1:0] op_idx_q, op_idx_next;
  aluop_t              alu_op_q;
  logic [31:0]         golden_q;
  logic                pass_q;
  logic [31:0]         a_q, b_q;
  logic [31:0]         misr_in, misr_next;
  logic                start_acc, run_step, last_vec;

  assign start_acc   = start && !abort && (state_q != BIST_RUN);
  assign run_step    = (state_q == BIST_RUN) && !abort;
  // Terminate on the last vector rather than after it, so an all-ones
  // num_vectors never needs the counter to wrap.
  assign last_vec    = run_step && (count_q == nv_q - CNT_W'(1));
  assign op_idx_next = (op_idx_q == OP_IDX_W'(NUM_OPS - 1)) ? '0 : op_idx_q + OP_IDX_W'(1);

  assign misr_in   = aluif.port_o ^ {29'b0, aluif.v_flag, aluif.n_flag, aluif.z_flag};
  // Same value the MISR cell loads this edge; needed here to register pass.
  assign misr_next = bist_step(signature) ^ misr_in;

  lfsr32 #(.INIT(SEED_A)) u_lfsr_a (
    .CLK(CLK), .nRST(nRST), .load(start_acc), .seed(SEED_A),
    .en(run_step), .xor_in(32'h0), .q(a_q)
  );

  lfsr32 #(.INIT(SEED_B)) u_lfsr_b (
    .CLK(CLK), .nRST(nRST), .load(start_acc), .seed(SEED_B),
    .en(run_step), .xor_in(32'h0), .q(b_q)
  );

  lfsr32 #(.INIT(MISR_SEED)) u_misr (
    .CLK(CLK), .nRST(nRST), .load(start_acc), .seed(MISR_SEED),
    .en(run_step), .xor_in(misr_in), .q(signature)
  );

  assign aluif.port_a = a_q;
  assign aluif.port_b = b_q;
  assign aluif.alu_op = alu_op_q;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= BIST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BIST_IDLE: begin
        if (start_acc) state_d = (num_vectors == '0) ? BIST_DONE : BIST_RUN;
      end
      BIST_RUN: begin
        if (abort)         state_d = BIST_IDLE;
        else if (last_vec) state_d = BIST_DONE;
      end
      BIST_DONE: begin
        if (abort)          state_d = BIST_IDLE;
        else if (start_acc) state_d = (num_vectors == '0) ? BIST_DONE : BIST_RUN;
      end
      default: state_d = BIST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      BIST_RUN:  busy = 1'b1;
      BIST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pass = pass_q;

  // Vector counter, op sequencing, latched run parameters and verdict
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q  <= '0;
      nv_q     <= '0;
      op_idx_q <= '0;
      alu_op_q <= OP_TABLE[0];
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else if (abort) begin
      pass_q <= 1'b0;
    end else if (start_acc) begin
      count_q  <= '0;
      nv_q     <= num_vectors;
      op_idx_q <= '0;
      alu_op_q <= OP_TABLE[0];
      golden_q <= golden;
      // An empty run goes straight to DONE with the seed as its signature.
      pass_q   <= (num_vectors == '0) && (MISR_SEED == golden);
    end else if (run_step) begin
      count_q  <= count_q + CNT_W'(1);
      op_idx_q <= op_idx_next;
      alu_op_q <= OP_TABLE[op_idx_next];
      if (last_vec) pass_q <= (misr_next == golden_q);
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - scoreboard bench for alu_bist with a behavioural ALU
module tb_alu_bist;
  import cpu_types_pkg::*;

  localparam logic [31:0] T_SEED_A = 32'h1234_5678;
  localparam logic [31:0] T_SEED_B = 32'h9ABC_DEF0;
  localparam logic [31:0] T_MISR   = 32'hFFFF_FFFF;
  localparam logic [31:0] T_POLY   = 32'h8020_0003;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [31:0] golden = '0;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic        fault = 1'b0;

  alu_if aluif();

  alu_bist #(
    .SEED_A(T_SEED_A), .SEED_B(T_SEED_B), .MISR_SEED(T_MISR), .CNT_W(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .abort(abort),
    .num_vectors(num_vectors), .golden(golden),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .aluif(aluif)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] o;
    logic        v;
    logic        n;
    logic        z;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [31:0] a, input logic [31:0] b,
                                        input aluop_t op, input logic flt);
    alu_res_t res;
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      default:  r = '0;
    endcase
    res.o = flt ? (r | 32'h1) : r;
    res.v = v;
    res.n = r[31];
    res.z = (r == 32'h0);
    return res;
  endfunction

  alu_res_t ar;
  assign ar = alu_eval(aluif.port_a, aluif.port_b, aluif.alu_op, fault);
  assign aluif.port_o = ar.o;
  assign aluif.v_flag = ar.v;
  assign aluif.n_flag = ar.n;
  assign aluif.z_flag = ar.z;

  aluop_t exp_ops [10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                           ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return x[31] ? ({x[30:0], 1'b0} ^ T_POLY) : {x[30:0], 1'b0};
  endfunction

  function automatic logic [31:0] ref_sig(input int nv, input logic flt);
    logic [31:0] a, b, m;
    alu_res_t r;
    a = T_SEED_A;
    b = T_SEED_B;
    m = T_MISR;
    for (int k = 0; k < nv; k++) begin
      r = alu_eval(a, b, exp_ops[k % 10], flt);
      m = ref_step(m) ^ r.o ^ {29'b0, r.v, r.n, r.z};
      a = ref_step(a);
      b = ref_step(b);
    end
    return m;
  endfunction

  function automatic logic [31:0] ref_steps(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int k = 0; k < n; k++) y = ref_step(y);
    return y;
  endfunction

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int unsigned cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done is one completed run.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
        end else begin
          e = sb_q.pop_front();
          check32("signature", signature, e.sig);
          check32("pass", {31'b0, pass}, {31'b0, e.pass});
          check32("done_latency", cyc, e.cyc);
        end
      end
      done_prev = done;
    end
  end

  // Pulse start for one cycle; returns at the negedge where vector 0 is driven.
  task automatic issue(input logic [15:0] nv, input logic [31:0] g,
                       input logic [31:0] exp_sig, input logic exp_pass, input bit push);
    @(negedge CLK);
    num_vectors = nv;
    golden      = g;
    start       = 1'b1;
    if (push) sb_q.push_back('{exp_sig, exp_pass, cyc + 32'(nv) + 1});
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", name, n);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_port_a"}, aluif.port_a, 32'h1234_5678);
    check32({tag, "_port_b"}, aluif.port_b, 32'h9ABC_DEF0);
    check32({tag, "_alu_op"}, 32'(aluif.alu_op), 32'(ALU_SLL));
    check32({tag, "_signature"}, signature, 32'hFFFF_FFFF);
    check32({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check32({tag, "_done"}, {31'b0, done}, 32'h0);
    check32({tag, "_pass"}, {31'b0, pass}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g23, g10, g20;
    g23 = ref_sig(23, 1'b0);
    g10 = ref_sig(10, 1'b0);
    g20 = ref_sig(20, 1'b0);

    // 1: reset values
    @(negedge CLK);
    check_reset_vals("reset");
    nRST = 1'b1;

    // 2: empty run completes after one edge with the seed signature
    issue(16'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check32("nv0_busy", {31'b0, busy}, 32'h0);
    check32("nv0_done", {31'b0, done}, 32'h1);

    // 3: single vector, SLL of 1234_5678 by 16
    issue(16'd1, 32'h29A7_FFFD, 32'h29A7_FFFD, 1'b1, 1'b1);
    check32("nv1_busy", {31'b0, busy}, 32'h1);
    wait_done("nv1");

    // 4: 23 vectors, op sequence wraps through the table
    issue(16'd23, g23, g23, 1'b1, 1'b1);
    for (int k = 0; k < 23; k++) begin
      check32("alu_op_seq", 32'(aluif.alu_op), 32'(exp_ops[k % 10]));
      if (k < 22) @(negedge CLK);
    end
    wait_done("nv23");

    // 4b: same golden with port_o[0] stuck at 1
    fault = 1'b1;
    issue(16'd23, g23, ref_sig(23, 1'b1), 1'b0, 1'b1);
    wait_done("nv23_fault");
    @(negedge CLK);
    fault = 1'b0;

    // 5a: start during RUN is ignored (length and golden unchanged)
    issue(16'd10, g10, g10, 1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    num_vectors = 16'd2;
    golden      = 32'h0;
    start       = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("restart_ignored");

    // 5b: abort after 5 vectors; registers hold, no completion
    issue(16'd10, g10, 32'h0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check32("abort_busy", {31'b0, busy}, 32'h0);
    check32("abort_done", {31'b0, done}, 32'h0);
    check32("abort_pass", {31'b0, pass}, 32'h0);
    check32("abort_sig_hold", signature, ref_sig(5, 1'b0));
    check32("abort_a_hold", aluif.port_a, ref_steps(T_SEED_A, 5));

    // 5c: abort together with start from DONE goes to IDLE without reload
    issue(16'd1, 32'h29A7_FFFD, 32'h29A7_FFFD, 1'b1, 1'b1);
    wait_done("nv1_again");
    @(negedge CLK);
    abort       = 1'b1;
    start       = 1'b1;
    num_vectors = 16'd3;
    @(negedge CLK);
    abort = 1'b0;
    start = 1'b0;
    check32("abort_start_busy", {31'b0, busy}, 32'h0);
    check32("abort_start_done", {31'b0, done}, 32'h0);
    check32("abort_start_pass", {31'b0, pass}, 32'h0);
    check32("abort_start_sig", signature, 32'h29A7_FFFD);
    @(negedge CLK);
    check32("abort_start_idle", {31'b0, busy}, 32'h0);

    // 6: asynchronous reset mid-run, then a clean run of 20
    issue(16'd20, g20, 32'h0, 1'b0, 1'b0);
    repeat (7) @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge CLK);
    nRST = 1'b1;
    issue(16'd20, g20, g20, 1'b1, 1'b1);
    wait_done("nv20");

    repeat (3) @(negedge CLK);
    check32("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
